// File: rtl/multivib_nch_pkg.sv
// multivib_nch_pkg: shared state encoding for the multivibrator channels
package multivib_pkg;
  localparam int MV_STATE_W = 3;
  typedef enum logic [MV_STATE_W-1:0] {IDLE, DELAY, PH1, PH2, DONE} mv_state_t;
endpackage

// File: rtl/multivib_nch_if.sv
// multivib_nch_if: per-channel control, configuration and waveform bus
interface multivib_nch_if #(parameter int NCH = 4, parameter int W = 32);
  logic [NCH-1:0]   en;
  logic             sync;
  logic [NCH*W-1:0] n0, n1, n2, nburst;
  logic [NCH-1:0]   y0, y, active, done;
  modport master (output en, sync, n0, n1, n2, nburst, y0, input y, active, done);
  modport slave (input en, sync, n0, n1, n2, nburst, y0, output y, active, done);
endinterface

// File: rtl/multivib_nch_ch.sv
// multivib_ch: one multivibrator channel with delay, two phases and burst count
module multivib_ch
  import multivib_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         sync_i,
  input  logic [W-1:0] n0_i,
  input  logic [W-1:0] n1_i,
  input  logic [W-1:0] n2_i,
  input  logic [W-1:0] nb_i,
  input  logic         y0_i,
  output logic         y_o,
  output logic         active_o,
  output logic         done_o
);
  mv_state_t state_q, state_d, ent_state, cyc_state;
  logic [W-1:0] cnt_q, cnt_d, pulse_q, pulse_d, n1_q, n2_q, nb_q, nb_d, c_n1, c_n2, ent_cnt, pulse_nx;
  logic y0_q, y0_d, y_q, y_d, active_q, done_q, start, burst_end;
  assign start = en_i && (sync_i || state_q == IDLE);
  assign c_n1 = start ? n1_i : n1_q;
  assign c_n2 = start ? n2_i : n2_q;
  assign nb_d = start ? nb_i : nb_q;
  assign y0_d = start ? y0_i : y0_q;
  // entry into a new cycle skips zero-length phases; both zero means done
  assign ent_state = c_n1 != '0 ? PH1 : c_n2 != '0 ? PH2 : DONE;
  assign ent_cnt = (c_n1 != '0 ? c_n1 : c_n2) - 1'b1;
  assign pulse_nx = pulse_q + 1'b1;
  assign burst_end = nb_q != '0 && pulse_nx == nb_q;
  assign cyc_state = burst_end ? DONE : ent_state;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q - 1'b1;
    pulse_d = pulse_q;
    if (!en_i) state_d = IDLE;
    else if (start) begin
      pulse_d = '0;
      state_d = n0_i != '0 ? DELAY : ent_state;
      cnt_d = n0_i != '0 ? n0_i - 1'b1 : ent_cnt;
    end else if (cnt_q == '0) begin
      case (state_q)
        DELAY: begin
          state_d = ent_state;
          cnt_d = ent_cnt;
        end
        PH1: begin
          state_d = c_n2 != '0 ? PH2 : cyc_state;
          cnt_d = c_n2 != '0 ? c_n2 - 1'b1 : ent_cnt;
          pulse_d = c_n2 != '0 ? pulse_q : pulse_nx;
        end
        PH2: begin
          state_d = cyc_state;
          cnt_d = ent_cnt;
          pulse_d = pulse_nx;
        end
        default: ;
      endcase
    end
  end
  assign y_d = state_d == IDLE ? y0_i : state_d == PH2 ? !y0_d : y0_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pulse_q <= '0;
      n1_q <= '0;
      n2_q <= '0;
      nb_q <= '0;
      y0_q <= 1'b0;
      y_q <= y0_i;
      active_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pulse_q <= pulse_d;
      n1_q <= c_n1;
      n2_q <= c_n2;
      nb_q <= nb_d;
      y0_q <= y0_d;
      y_q <= y_d;
      active_q <= state_d == DELAY || state_d == PH1 || state_d == PH2;
      done_q <= state_d == DONE;
    end
  end
  assign y_o = y_q;
  assign active_o = active_q;
  assign done_o = done_q;
endmodule

// File: rtl/multivib_nch.sv
// multivib_nch: NCH independent multivibrator channels sharing a sync strobe
module multivib_nch #(
  parameter int NCH = 4,
  parameter int W = 32
) (
  input logic            clk,
  input logic            rst,
  multivib_nch_if.slave  bus
);
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    multivib_ch #(.W(W)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en_i     (bus.en[i]),
      .sync_i   (bus.sync),
      .n0_i     (bus.n0[i*W +: W]),
      .n1_i     (bus.n1[i*W +: W]),
      .n2_i     (bus.n2[i*W +: W]),
      .nb_i     (bus.nburst[i*W +: W]),
      .y0_i     (bus.y0[i]),
      .y_o      (bus.y[i]),
      .active_o (bus.active[i]),
      .done_o   (bus.done[i])
    );
  end
endmodule

// File: tb/tb_multivib_nch.sv
// tb_multivib_nch: directed vectors and waveform sequences for multivib_nch
module tb_multivib_nch;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  multivib_nch_if #(.NCH(2), .W(W)) b ();
  multivib_nch_if #(.NCH(1), .W(4)) b4 ();
  multivib_nch #(.NCH(2), .W(W)) dut (.clk(clk), .rst(rst), .bus(b));
  multivib_nch #(.NCH(1), .W(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  typedef struct {
    logic en;
    logic sync;
    logic ey;
    logic ea;
    logic ed;
  } vec_t;
  vec_t tbl[14];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: {y,active,done} got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_ch(input string nm, input int ch, input logic ey, input logic ea, input logic ed);
    chk(nm, {b.y[ch], b.active[ch], b.done[ch]}, {ey, ea, ed});
  endtask
  task automatic cfg(input int ch, input logic [W-1:0] a0, input logic [W-1:0] a1,
                     input logic [W-1:0] a2, input logic [W-1:0] ab, input logic yv);
    b.n0[ch*W +: W] = a0;
    b.n1[ch*W +: W] = a1;
    b.n2[ch*W +: W] = a2;
    b.nburst[ch*W +: W] = ab;
    b.y0[ch] = yv;
  endtask
  function automatic logic exp_y(input int k, input int n0, input int n1, input int n2, input logic y0);
    if (k < n0 + n1) return y0;
    return ((k - n0 - n1) % (n1 + n2) < n2) ? !y0 : y0;
  endfunction
  initial begin
    tbl[0]  = '{1, 0, 0, 1, 0};
    tbl[1]  = '{1, 0, 1, 1, 0};
    tbl[2]  = '{1, 0, 0, 1, 0};
    tbl[3]  = '{1, 0, 1, 1, 0};
    tbl[4]  = '{1, 0, 0, 1, 0};
    tbl[5]  = '{1, 0, 1, 1, 0};
    tbl[6]  = '{1, 0, 0, 0, 1};
    tbl[7]  = '{1, 0, 0, 0, 1};
    tbl[8]  = '{1, 0, 0, 0, 1};
    tbl[9]  = '{1, 1, 0, 1, 0};
    tbl[10] = '{1, 0, 1, 1, 0};
    tbl[11] = '{0, 1, 0, 0, 0};
    tbl[12] = '{1, 1, 0, 1, 0};
    tbl[13] = '{1, 0, 1, 1, 0};
    rst = 1'b1;
    b.en = '0;
    b.sync = 1'b0;
    b.n0 = '0;
    b.n1 = '0;
    b.n2 = '0;
    b.nburst = '0;
    b.y0 = 2'b01;
    b4.en = '0;
    b4.sync = 1'b0;
    b4.n0 = 4'd0;
    b4.n1 = 4'd15;
    b4.n2 = 4'd15;
    b4.nburst = 4'd0;
    b4.y0 = 1'b0;
    tick();
    tick();
    chk_ch("reset_ch0", 0, 1'b1, 1'b0, 1'b0);
    chk_ch("reset_ch1", 1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    b.y0 = 2'b10;
    tick();
    chk_ch("idle_follow_ch0", 0, 1'b0, 1'b0, 1'b0);
    chk_ch("idle_follow_ch1", 1, 1'b1, 1'b0, 1'b0);
    b.y0 = 2'b00;
    cfg(0, 3, 2, 4, 0, 0);
    b.en[0] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      chk_ch("continuous", 0, exp_y(k, 3, 2, 4, 1'b0), 1'b1, 1'b0);
    end
    b.en[0] = 1'b0;
    tick();
    chk_ch("en_drop_idle", 0, 1'b0, 1'b0, 1'b0);
    cfg(0, 0, 1, 1, 3, 0);
    for (int i = 0; i < 14; i++) begin
      b.en[0] = tbl[i].en;
      b.sync = tbl[i].sync;
      tick();
      chk_ch($sformatf("burst_vec%0d", i), 0, tbl[i].ey, tbl[i].ea, tbl[i].ed);
    end
    b.sync = 1'b0;
    b.en = '0;
    tick();
    cfg(0, 3, 2, 4, 0, 0);
    cfg(1, 1, 3, 2, 0, 1);
    b.en = 2'b11;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk_ch("freeze_ch0", 0, exp_y(k, 3, 2, 4, 1'b0), 1'b1, 1'b0);
      chk_ch("freeze_ch1", 1, exp_y(k, 1, 3, 2, 1'b1), 1'b1, 1'b0);
      if (k == 2) b.n2[0 +: W] = 8'd7;
    end
    b.sync = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      b.sync = 1'b0;
      chk_ch("sync_ch0", 0, exp_y(k, 3, 2, 7, 1'b0), 1'b1, 1'b0);
      chk_ch("sync_ch1", 1, exp_y(k, 1, 3, 2, 1'b1), 1'b1, 1'b0);
    end
    b.en[1] = 1'b0;
    tick();
    chk_ch("drop_ph2_ch1", 1, 1'b1, 1'b0, 1'b0);
    b.en[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_ch("restart_ch1", 1, exp_y(k, 1, 3, 2, 1'b1), 1'b1, 1'b0);
    end
    b.en = '0;
    tick();
    cfg(0, 4, 0, 0, 0, 0);
    b.en[0] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk_ch("degenerate", 0, 1'b0, k < 4, k >= 4);
    end
    b.en = '0;
    tick();
    cfg(0, 1, 1, 5, 0, 0);
    b.en[0] = 1'b1;
    tick();
    tick();
    tick();
    chk_ch("pre_rst_ph2", 0, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    cfg(0, 0, 2, 3, 0, 1);
    tick();
    chk_ch("mid_rst", 0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk_ch("post_rst", 0, exp_y(k, 0, 2, 3, 1'b1), 1'b1, 1'b0);
    end
    b.en = '0;
    b4.en = 1'b1;
    for (int k = 0; k < 540; k++) begin
      tick();
      chk("w4_wrap", {b4.y[0], b4.active[0], b4.done[0]}, {exp_y(k, 0, 15, 15, 1'b0), 1'b1, 1'b0});
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/multivib_nch.md
# multivib_nch

Parametrised multi-channel multivibrator. Each of NCH independent channels produces a programmable waveform: a startup delay, then a repeating two-phase cycle (idle level, then inverted level). The cycle repeats either for a programmed burst count or continuously. Channel configuration is captured when the channel starts and is frozen for the rest of the run. A shared `sync` strobe restarts all enabled channels on the same clock. The block drives trigger, gate and LED-blink outputs in front-end and test-pulser logic.

## Interface
Parameters:
- `NCH`, 4: number of channels (1..32).
- `W`, 32: width of every count field.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `en`, in, NCH: per-channel enable (level).
- `sync`, in, 1: one-cycle restart strobe for all channels whose `en` is high.
- `n0`, in, NCH*W: startup delay in cycles; channel i uses `[i*W +: W]`.
- `n1`, in, NCH*W: phase-1 length in cycles; output at idle level.
- `n2`, in, NCH*W: phase-2 length in cycles; output at inverted level.
- `nburst`, in, NCH*W: number of phase-1/phase-2 cycles to run; 0 means continuous.
- `y0`, in, NCH: idle level per channel.
- `y`, out, NCH: registered waveform output.
- `active`, out, NCH: channel is in DELAY, PH1 or PH2.
- `done`, out, NCH: burst complete; held until the channel leaves DONE.

## Operation
- States per channel: IDLE, DELAY, PH1, PH2, DONE.
- Start: in IDLE with `en`=1, or in any state with `en`=1 and `sync`=1.
  - Latch n0, n1, n2, nburst and y0 into shadow registers.
  - Enter DELAY, or PH1 directly if n0=0.
- DELAY: lasts n0 cycles, then PH1.
- PH1: lasts n1 cycles, then PH2. If n1=0, PH1 is skipped.
- PH2: lasts n2 cycles. If n2=0, PH2 is skipped. At the end of PH2:
  - Increment the pulse counter.
  - If nburst≠0 and pulse counter = nburst, go to DONE; otherwise go to PH1.
- Degenerate config: n1=0 and n2=0 sends the channel straight to DONE after DELAY, so it never locks up.
- DONE: `y` at latched y0, `done`=1. Stays in DONE until `en`=0 or `sync`.
- `en`=0 in any state: go to IDLE on the next edge; `done` and `active` clear.
- IDLE: `y` follows live `y0`, registered.
- Output levels:
  - `y` = !y0_latched in PH2.
  - `y` = y0_latched in DELAY, PH1 and DONE.
  - `y` = y0 in IDLE.
- Changes to configuration inputs during a run are ignored until the next start.
- Priority: `rst` > `en`=0 > `sync` > normal sequencing.
- Arithmetic:
  - Phase counter is W bits and counts down from length−1.
  - Pulse counter is W bits and compared for equality with nburst.
  - When nburst=0, the pulse counter is allowed to wrap freely.

## Timing
- Reset values: all channels IDLE; `y` = live `y0` after the reset edge; `active`=0; `done`=0.
- Define E0 as the edge that samples the start condition.
  - `active` rises at E0.
  - `y` goes to !y0 at edge E0+n0+n1 and returns to y0 at E0+n0+n1+n2.
- Period is n1+n2 cycles; high/low widths are exact, with no extra cycle at phase boundaries.
- With nburst=B: DONE and `done`=1 take effect at edge E0+n0+B·(n1+n2).
- `en` falling sampled at edge Ef: state is IDLE after Ef and `y` = y0 after Ef (one-cycle latency).
- `sync` during a run: the channel restarts at that edge; the pulse counter clears and phase timing is exactly as for E0.
- Channels with `en`=0 ignore `sync`.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `multivib_pkg` holds:
  - the state enum `mv_state_t` (IDLE, DELAY, PH1, PH2, DONE);
  - localparam widths for the state encoding.
- Sub-module `multivib_ch`: one channel, parameter W, scalar ports.
- Top level: a generate loop instantiates NCH copies, slices the packed buses and fans out `sync`.

## Test plan
- NCH=2, W=8; ch0: n0=3, n1=2, n2=4, y0=0, nburst=0; `en` rises.
  - `y[0]` first high at E0+5 for 4 cycles.
  - Then period 6 continuously.
  - `done`=0 throughout.
- Burst: n0=0, n1=1, n2=1, nburst=3.
  - Exactly 3 single-cycle highs.
  - `done`=1 at E0+6, held.
  - `active` falls at the same edge.
- Config freeze and `sync`:
  - Change n2 from 4 to 7 mid-run: no effect on the current run.
  - Pulse `sync`: new n2=7 used, and the restart is aligned to the `sync` edge on both channels.
- `en` dropped mid-PH2 with y0=1:
  - `y` returns to 1 one cycle later.
  - Re-raising `en` restarts from DELAY.
- Degenerate and wrap cases:
  - n1=n2=0 gives `done` after n0 cycles.
  - W=4 with n1=15, n2=15 gives correct 30-cycle period.
  - nburst=0 runs past 16 pulses with no stall.
- `rst` asserted mid-PH2:
  - All outputs at reset values after the edge.
  - Configuration re-latched on the next start.
